// File: rtl/kamus_mem_arbiter.sv
// Two-requester memory arbiter: the fetch stage and the LSU share one single-port memory bus.
// LSU has fixed priority. A saturating starvation counter forces a fetch grant after STARVE_LIMIT consecutive LSU wins.
module kamus_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned ADDR_WIDTH   = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  if_req_i,
  input  logic [ADDR_WIDTH-1:0] if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  lsu_req_i,
  input  logic                  lsu_we_i,
  input  logic [3:0]            lsu_be_i,
  input  logic [ADDR_WIDTH-1:0] lsu_addr_i,
  input  logic [31:0]           lsu_wdata_i,
  output logic                  lsu_gnt_o,
  output logic                  lsu_rvalid_o,
  output logic [31:0]           lsu_rdata_o,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  input  logic                  mem_gnt_i,
  input  logic                  mem_rvalid_i,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_e;

  state_e        state;
  logic [CW-1:0] starve_cnt;
  logic          owner_if;
  logic          starved;
  logic          fetch_win;
  logic          lsu_win;

  // Grants are withheld while reset is asserted, because nothing is latched in that cycle.
  always_comb begin
    starved   = (starve_cnt == CW'(STARVE_LIMIT));
    fetch_win = !rst_i && (state == S_IDLE) && if_req_i && (!lsu_req_i || starved);
    lsu_win   = !rst_i && (state == S_IDLE) && lsu_req_i && !fetch_win;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state       <= S_IDLE;
      starve_cnt  <= '0;
      owner_if    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_be_o    <= '0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (fetch_win) begin
            owner_if   <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_be_o   <= '1;
            mem_addr_o <= if_addr_i;
            starve_cnt <= '0;
            state      <= S_REQ;
          end else if (lsu_win) begin
            owner_if    <= 1'b0;
            mem_we_o    <= lsu_we_i;
            mem_be_o    <= lsu_be_i;
            mem_addr_o  <= lsu_addr_i;
            mem_wdata_o <= lsu_wdata_i;
            state       <= S_REQ;
            if (!if_req_i) begin
              starve_cnt <= '0;
            end else if (!starved) begin
              starve_cnt <= starve_cnt + 1'b1;
            end
          end else begin
            starve_cnt <= '0;
          end
        end
        S_REQ: begin
          if (mem_gnt_i) begin
            state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_rvalid_i) begin
            state <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    if_gnt_o     = fetch_win;
    lsu_gnt_o    = lsu_win;
    mem_req_o    = (state == S_REQ);
    busy_o       = (state != S_IDLE);
    if_rvalid_o  = (state == S_WAIT) && mem_rvalid_i && owner_if;
    lsu_rvalid_o = (state == S_WAIT) && mem_rvalid_i && !owner_if;
    if_rdata_o   = mem_rdata_i;
    lsu_rdata_o  = mem_rdata_i;
  end

endmodule

// File: tb/tb_kamus_mem_arbiter.sv
// Directed bench for kamus_mem_arbiter: expected memory transactions are queued at grant time
// and compared when the arbiter presents them on the memory bus.
module tb_kamus_mem_arbiter;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        if_req_i;
  logic [31:0] if_addr_i;
  logic        if_gnt_o, if_rvalid_o;
  logic [31:0] if_rdata_o;
  logic        lsu_req_i, lsu_we_i;
  logic [3:0]  lsu_be_i;
  logic [31:0] lsu_addr_i, lsu_wdata_i;
  logic        lsu_gnt_o, lsu_rvalid_o;
  logic [31:0] lsu_rdata_o;
  logic        mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;
  logic [31:0] mem_addr_o, mem_wdata_o;
  logic        mem_gnt_i, mem_rvalid_i;
  logic [31:0] mem_rdata_i;
  logic        busy_o;

  kamus_mem_arbiter #(.STARVE_LIMIT(4), .ADDR_WIDTH(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_be_i(lsu_be_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o),
    .lsu_rvalid_o(lsu_rvalid_o), .lsu_rdata_o(lsu_rdata_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o),
    .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
    .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        own_if;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
  } txn_t;

  txn_t sb[$];
  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_mem(input txn_t e);
    chk("mem_req", mem_req_o, 1'b1);
    chk("busy_req", busy_o, 1'b1);
    chk("mem_addr", mem_addr_o, e.addr);
    chk("mem_we", mem_we_o, e.we);
    chk("mem_be", mem_be_o, e.be);
    if (!e.own_if) chk("mem_wdata", mem_wdata_o, e.wdata);
  endtask

  task automatic chk_zero_outputs(input string tag);
    chk({tag, "_if_gnt"}, if_gnt_o, 1'b0);
    chk({tag, "_lsu_gnt"}, lsu_gnt_o, 1'b0);
    chk({tag, "_if_rvalid"}, if_rvalid_o, 1'b0);
    chk({tag, "_lsu_rvalid"}, lsu_rvalid_o, 1'b0);
    chk({tag, "_mem_req"}, mem_req_o, 1'b0);
    chk({tag, "_mem_we"}, mem_we_o, 1'b0);
    chk({tag, "_mem_be"}, mem_be_o, 4'h0);
    chk({tag, "_mem_addr"}, mem_addr_o, 32'h0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 32'h0);
    chk({tag, "_busy"}, busy_o, 1'b0);
  endtask

  // Called at a negedge in IDLE with requests already driven; ends at a negedge back in IDLE.
  task automatic txn(input bit exp_if, input bit keep, input int unsigned gdly,
                     input bit spur, input logic [31:0] rd);
    txn_t t, e;
    logic s_if, s_lsu, s_we;
    logic [3:0] s_be;
    logic [31:0] s_addr, s_wd;
    #1;
    chk("if_gnt", if_gnt_o, exp_if);
    chk("lsu_gnt", lsu_gnt_o, !exp_if);
    t.own_if = exp_if;
    t.addr   = exp_if ? if_addr_i : lsu_addr_i;
    t.we     = exp_if ? 1'b0 : lsu_we_i;
    t.be     = exp_if ? 4'hF : lsu_be_i;
    t.wdata  = lsu_wdata_i;
    sb.push_back(t);
    @(negedge clk_i);
    if (!keep) begin
      if (exp_if) begin
        if_req_i = 1'b0; if_addr_i = ~if_addr_i;
      end else begin
        lsu_req_i = 1'b0; lsu_addr_i = ~lsu_addr_i; lsu_we_i = ~lsu_we_i;
        lsu_be_i = ~lsu_be_i; lsu_wdata_i = ~lsu_wdata_i;
      end
    end
    #1;
    e = sb.pop_front();
    chk_mem(e);
    s_if = if_req_i; s_lsu = lsu_req_i; s_we = lsu_we_i;
    s_be = lsu_be_i; s_addr = lsu_addr_i; s_wd = lsu_wdata_i;
    for (int unsigned i = 0; i < gdly; i++) begin
      if_req_i    = 1'b1;
      lsu_req_i   = ~lsu_req_i;
      lsu_we_i    = ~lsu_we_i;
      lsu_be_i    = 4'($urandom);
      lsu_addr_i  = $urandom;
      lsu_wdata_i = $urandom;
      #1;
      chk("stall_if_gnt", if_gnt_o, 1'b0);
      chk("stall_lsu_gnt", lsu_gnt_o, 1'b0);
      chk_mem(e);
      @(negedge clk_i);
    end
    if_req_i = s_if; lsu_req_i = s_lsu; lsu_we_i = s_we;
    lsu_be_i = s_be; lsu_addr_i = s_addr; lsu_wdata_i = s_wd;
    mem_gnt_i = 1'b1;
    if (spur) begin
      mem_rvalid_i = 1'b1;
      mem_rdata_i  = ~rd;
    end
    #1;
    chk("gntcyc_if_rvalid", if_rvalid_o, 1'b0);
    chk("gntcyc_lsu_rvalid", lsu_rvalid_o, 1'b0);
    chk_mem(e);
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    mem_rvalid_i = 1'b0;
    #1;
    chk("wait_busy", busy_o, 1'b1);
    chk("wait_mem_req", mem_req_o, 1'b0);
    chk("wait_if_rvalid", if_rvalid_o, 1'b0);
    chk("wait_lsu_rvalid", lsu_rvalid_o, 1'b0);
    mem_rvalid_i = 1'b1;
    mem_rdata_i  = rd;
    #1;
    chk("if_rvalid", if_rvalid_o, e.own_if);
    chk("lsu_rvalid", lsu_rvalid_o, !e.own_if);
    chk("wait_if_gnt", if_gnt_o, 1'b0);
    chk("wait_lsu_gnt", lsu_gnt_o, 1'b0);
    if (e.own_if) chk("if_rdata", if_rdata_o, rd);
    else chk("lsu_rdata", lsu_rdata_o, rd);
    @(negedge clk_i);
    mem_rvalid_i = 1'b0;
    #1;
    chk("idle_busy", busy_o, 1'b0);
  endtask

  initial begin
    rst_i = 1'b1;
    if_req_i = 1'b0; if_addr_i = '0;
    lsu_req_i = 1'b0; lsu_we_i = 1'b0; lsu_be_i = '0; lsu_addr_i = '0; lsu_wdata_i = '0;
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
    repeat (2) @(negedge clk_i);
    #1;
    chk_zero_outputs("rst");
    @(negedge clk_i);
    rst_i = 1'b0;

    // Single fetch, best-case latency
    if_req_i = 1'b1; if_addr_i = 32'h100;
    txn(1'b1, 1'b0, 0, 1'b0, 32'hDEADBEEF);

    // Simultaneous fetch and LSU write: LSU first, then fetch
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h200;
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h300; lsu_wdata_i = 32'h55; lsu_be_i = 4'h3;
    txn(1'b0, 1'b0, 0, 1'b0, 32'h0);
    txn(1'b1, 1'b0, 0, 1'b0, 32'h12345678);

    // Spurious memory handshakes in IDLE, then rvalid in the mem_gnt cycle
    @(negedge clk_i);
    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'hBAD;
    #1;
    chk("spur_if_rvalid", if_rvalid_o, 1'b0);
    chk("spur_lsu_rvalid", lsu_rvalid_o, 1'b0);
    @(negedge clk_i);
    mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
    #1;
    chk("spur_busy", busy_o, 1'b0);
    chk("spur_mem_req", mem_req_o, 1'b0);
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h340; lsu_be_i = 4'hC;
    txn(1'b0, 1'b0, 0, 1'b1, 32'hCAFE0001);

    // Memory back-pressure
    @(negedge clk_i);
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_addr_i = 32'h400; lsu_be_i = 4'hF; lsu_wdata_i = 32'h0BADF00D;
    txn(1'b0, 1'b0, 5, 1'b0, 32'hA5A5A5A5);

    // Starvation: continuous requests give L L L L F L L L L F
    @(negedge clk_i);
    if_req_i = 1'b1; if_addr_i = 32'h500;
    lsu_req_i = 1'b1; lsu_we_i = 1'b0; lsu_addr_i = 32'h600; lsu_be_i = 4'hF;
    for (int unsigned k = 0; k < 10; k++) begin
      txn(k % 5 == 4, 1'b1, 0, 1'b0, 32'h1000 + k);
    end
    if_req_i = 1'b0; lsu_req_i = 1'b0;
    @(negedge clk_i);

    // Reset in WAIT with the counter at its limit; reset must clear it
    if_req_i = 1'b1; lsu_req_i = 1'b1;
    for (int unsigned k = 0; k < 3; k++) begin
      txn(1'b0, 1'b1, 0, 1'b0, 32'h2000 + k);
    end
    #1;
    chk("pre_rst_lsu_gnt", lsu_gnt_o, 1'b1);
    @(negedge clk_i);
    mem_gnt_i = 1'b1;
    @(negedge clk_i);
    mem_gnt_i = 1'b0;
    rst_i = 1'b1;
    @(negedge clk_i);
    #1;
    chk_zero_outputs("rstwait");
    @(negedge clk_i);
    rst_i = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'hFEEDFACE;
    #1;
    chk("late_if_rvalid", if_rvalid_o, 1'b0);
    chk("late_lsu_rvalid", lsu_rvalid_o, 1'b0);
    chk("late_busy", busy_o, 1'b0);
    mem_rvalid_i = 1'b0;
    txn(1'b0, 1'b0, 0, 1'b0, 32'h3000);
    if_req_i = 1'b0;
    @(negedge clk_i);

    chk("sb_empty", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
